// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the staged board reset controller.
// Imported by reset_sequencer and sync_debounce.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_POR    = 2'b00,
    CAUSE_MANUAL = 2'b01,
    CAUSE_LOCK   = 2'b10
  } cause_t;

  function automatic int max2(
    input int a,
    input int b
  );
    return (a > b) ? a : b;
  endfunction

  function automatic int cnt_width(
    input int a,
    input int b,
    input int c,
    input int d
  );
    return $clog2(max2(max2(a, b), max2(c, d)) + 1);
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a level debouncer for the
// manual reset button.
module sync_debounce
  import reset_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CW              = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk_i,
  input  logic nrst_i,
  input  logic raw_i,
  output logic db_o
);

  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          man_s;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          db_q;
  logic          db_d;

  assign man_s = sync_q[1];
  assign db_o  = db_q;

  // Counter only runs while the synced level disagrees with db_q.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (man_s != db_q) begin
      if (cnt_q == DB_LAST) begin
        db_d = man_s;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      sync_q <= '0;
      cnt_q  <= '0;
      db_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      cnt_q  <= cnt_d;
      db_q   <= db_d;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Board reset controller: waits for PLL lock, then releases N_OUT
// resets in staggered order; handles button and lock-loss resets.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int N_OUT           = 3,
  parameter int HOLD_CYCLES     = 4,
  parameter int GAP_CYCLES      = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             manual,
  input  logic             pll_lock,
  output logic [N_OUT-1:0] rst_out,
  output logic             busy,
  output logic             rst_done,
  output logic [1:0]       cause
);

  localparam int CW = cnt_width(
    N_OUT, HOLD_CYCLES, GAP_CYCLES, DEBOUNCE_CYCLES
  );

  localparam logic [CW-1:0]    HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]    GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0]    IDX_LAST  = CW'(N_OUT - 1);
  localparam logic [N_OUT-1:0] ALL_ONES  = '1;

  logic [1:0]       lock_sync_q;
  logic             lock_s;
  logic             man_db;
  logic             man_prev_q;
  logic             man_rise;

  state_t           state_q;
  state_t           state_d;
  logic [CW-1:0]    hold_q;
  logic [CW-1:0]    hold_d;
  logic [CW-1:0]    gap_q;
  logic [CW-1:0]    gap_d;
  logic [CW-1:0]    idx_q;
  logic [CW-1:0]    idx_d;
  logic [N_OUT-1:0] rst_q;
  logic [N_OUT-1:0] rst_d;
  cause_t           cause_q;
  cause_t           cause_d;
  logic             busy_q;
  logic             busy_d;
  logic             done_q;
  logic             done_d;

  sync_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CW              (CW)
  ) u_man_db (
    .clk_i  (clk),
    .nrst_i (nrst),
    .raw_i  (manual),
    .db_o   (man_db)
  );

  assign lock_s   = lock_sync_q[1];
  assign man_rise = man_db & ~man_prev_q;

  assign rst_out  = rst_q;
  assign busy     = busy_q;
  assign rst_done = done_q;
  assign cause    = cause_q;

  // Release order is a left shift: bit 0 clears first, higher bits follow.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    cause_d = cause_q;
    unique case (state_q)
      WAIT_LOCK: begin
        rst_d = ALL_ONES;
        if (lock_s) begin
          state_d = HOLD;
          hold_d  = '0;
        end
      end
      HOLD: begin
        rst_d = ALL_ONES;
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cause_d = CAUSE_LOCK;
        end else if (man_db) begin
          hold_d = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d = RELEASE;
          idx_d   = '0;
          gap_d   = '0;
          rst_d   = ALL_ONES << 1;
        end else begin
          hold_d = hold_q + CW'(1);
        end
      end
      RELEASE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          rst_d   = ALL_ONES;
          cause_d = CAUSE_LOCK;
        end else if (man_db) begin
          state_d = HOLD;
          hold_d  = '0;
          rst_d   = ALL_ONES;
          cause_d = CAUSE_MANUAL;
        end else if (idx_q == IDX_LAST) begin
          state_d = RUN;
          rst_d   = '0;
        end else if (gap_q == GAP_LAST) begin
          gap_d = '0;
          idx_d = idx_q + CW'(1);
          rst_d = rst_q << 1;
        end else begin
          gap_d = gap_q + CW'(1);
        end
      end
      RUN: begin
        rst_d = '0;
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          rst_d   = ALL_ONES;
          cause_d = CAUSE_LOCK;
        end else if (man_rise) begin
          state_d = HOLD;
          hold_d  = '0;
          rst_d   = ALL_ONES;
          cause_d = CAUSE_MANUAL;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        rst_d   = ALL_ONES;
      end
    endcase
  end

  assign busy_d = (state_d != RUN);
  assign done_d = (state_d == RUN) && (state_q != RUN);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      lock_sync_q <= '0;
      man_prev_q  <= 1'b0;
      state_q     <= WAIT_LOCK;
      hold_q      <= '0;
      gap_q       <= '0;
      idx_q       <= '0;
      rst_q       <= ALL_ONES;
      cause_q     <= CAUSE_POR;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      lock_sync_q <= {lock_sync_q[0], pll_lock};
      man_prev_q  <= man_db;
      state_q     <= state_d;
      hold_q      <= hold_d;
      gap_q       <= gap_d;
      idx_q       <= idx_d;
      rst_q       <= rst_d;
      cause_q     <= cause_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: power-on table, button,
// lock loss, coincident events and a parameter sweep.
module tb_reset_sequencer;
  import reset_seq_pkg::*;

  logic       clk = 1'b0;
  logic       nrst;
  logic       manual;
  logic       pll_lock;

  logic [2:0] rst_a;
  logic       busy_a;
  logic       done_a;
  logic [1:0] cause_a;
  logic [0:0] rst_b;
  logic       busy_b;
  logic       done_b;
  logic [1:0] cause_b;
  logic [7:0] rst_c;
  logic       busy_c;
  logic       done_c;
  logic [1:0] cause_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reset_sequencer u_dut (
    .clk      (clk),
    .nrst     (nrst),
    .manual   (manual),
    .pll_lock (pll_lock),
    .rst_out  (rst_a),
    .busy     (busy_a),
    .rst_done (done_a),
    .cause    (cause_a)
  );

  reset_sequencer #(
    .N_OUT       (1),
    .HOLD_CYCLES (1)
  ) u_n1 (
    .clk      (clk),
    .nrst     (nrst),
    .manual   (manual),
    .pll_lock (pll_lock),
    .rst_out  (rst_b),
    .busy     (busy_b),
    .rst_done (done_b),
    .cause    (cause_b)
  );

  reset_sequencer #(
    .N_OUT      (8),
    .GAP_CYCLES (3)
  ) u_n8 (
    .clk      (clk),
    .nrst     (nrst),
    .manual   (manual),
    .pll_lock (pll_lock),
    .rst_out  (rst_c),
    .busy     (busy_c),
    .rst_done (done_c),
    .cause    (cause_c)
  );

  typedef struct {
    logic       nrst;
    logic       lock;
    logic       man;
    logic [2:0] rst;
    logic       busy;
    logic       done;
    logic [1:0] cause;
  } vec_t;

  vec_t vt[16];

  // d = edges since L; negative d means still before lock is seen.
  function automatic logic [7:0] exp_rst(int d, int h, int g, int n);
    int rel;
    logic [7:0] m;
    if (d < h) rel = 0;
    else begin
      rel = (d - h) / g + 1;
      if (rel > n) rel = n;
    end
    m = '0;
    for (int i = 0; i < n; i++) if (i >= rel) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic exp_busy(int d, int h, int g, int n);
    return d <= h + (n - 1) * g;
  endfunction

  function automatic logic exp_done(int d, int h, int g, int n);
    return d == h + (n - 1) * g + 1;
  endfunction

  function automatic vec_t mk(logic r, logic [2:0] o, logic b, logic dn);
    vec_t v;
    v.nrst  = r;
    v.lock  = 1'b1;
    v.man   = 1'b0;
    v.rst   = o;
    v.busy  = b;
    v.done  = dn;
    v.cause = 2'b00;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_dflt(input int d, input logic [1:0] c);
    chk("rst_out", 32'(rst_a), 32'(exp_rst(d, 4, 2, 3)));
    chk("busy", 32'(busy_a), 32'(exp_busy(d, 4, 2, 3)));
    chk("rst_done", 32'(done_a), 32'(exp_done(d, 4, 2, 3)));
    chk("cause", 32'(cause_a), 32'(c));
  endtask

  task automatic check_sweep(input int d);
    chk("n1_rst", 32'(rst_b), 32'(exp_rst(d, 1, 2, 1)));
    chk("n1_busy", 32'(busy_b), 32'(exp_busy(d, 1, 2, 1)));
    chk("n1_done", 32'(done_b), 32'(exp_done(d, 1, 2, 1)));
    chk("n1_noX", 32'($isunknown({rst_b, busy_b, done_b, cause_b})), 0);
    chk("n8_rst", 32'(rst_c), 32'(exp_rst(d, 4, 3, 8)));
    chk("n8_busy", 32'(busy_c), 32'(exp_busy(d, 4, 3, 8)));
    chk("n8_done", 32'(done_c), 32'(exp_done(d, 4, 3, 8)));
    chk("n8_noX", 32'($isunknown({rst_c, busy_c, done_c, cause_c})), 0);
  endtask

  task automatic do_reset(input logic lk);
    nrst     = 1'b0;
    pll_lock = lk;
    manual   = 1'b0;
    tick();
    tick();
    nrst = 1'b1;
  endtask

  initial begin
    nrst     = 1'b0;
    manual   = 1'b0;
    pll_lock = 1'b1;
    @(negedge clk);

    // Power-on with lock present: L is the third edge after release.
    for (int i = 0; i < 3; i++) vt[i] = mk(1'b0, 3'b111, 1'b1, 1'b0);
    for (int i = 3; i < 9; i++) vt[i] = mk(1'b1, 3'b111, 1'b1, 1'b0);
    vt[9]  = mk(1'b1, 3'b110, 1'b1, 1'b0);
    vt[10] = mk(1'b1, 3'b110, 1'b1, 1'b0);
    vt[11] = mk(1'b1, 3'b100, 1'b1, 1'b0);
    vt[12] = mk(1'b1, 3'b100, 1'b1, 1'b0);
    vt[13] = mk(1'b1, 3'b000, 1'b1, 1'b0);
    vt[14] = mk(1'b1, 3'b000, 1'b0, 1'b1);
    vt[15] = mk(1'b1, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      nrst     = vt[i].nrst;
      pll_lock = vt[i].lock;
      manual   = vt[i].man;
      tick();
      chk("tbl_rst", 32'(rst_a), 32'(vt[i].rst));
      chk("tbl_busy", 32'(busy_a), 32'(vt[i].busy));
      chk("tbl_done", 32'(done_a), 32'(vt[i].done));
      chk("tbl_cause", 32'(cause_a), 32'(vt[i].cause));
    end

    // Bouncing button: 5-cycle pulses never survive the debouncer.
    for (int c = 0; c < 60; c++) begin
      manual = ((c / 5) % 2) == 0;
      tick();
      chk("bounce_rst", 32'(rst_a), 0);
      chk("bounce_busy", 32'(busy_a), 0);
    end
    manual = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      chk("held_rst", 32'(rst_a), (k >= 19) ? 32'h7 : 32'h0);
      chk("held_cause", 32'(cause_a), (k >= 19) ? 32'h1 : 32'h0);
    end
    manual = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      check_dflt(k - 18, 2'b01);
    end

    // Lock loss just after rst_out[0] falls, then relock.
    do_reset(1'b1);
    for (int k = 1; k <= 7; k++) begin
      tick();
      check_dflt(k - 3, 2'b00);
    end
    pll_lock = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      tick();
      check_dflt(k + 4, 2'b00);
    end
    tick();
    chk("loss_rst", 32'(rst_a), 32'h7);
    chk("loss_cause", 32'(cause_a), 32'h2);
    chk("loss_state", 32'(u_dut.state_q), 32'(WAIT_LOCK));
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("unlocked_rst", 32'(rst_a), 32'h7);
      chk("unlocked_busy", 32'(busy_a), 32'h1);
    end
    pll_lock = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check_dflt(k - 3, 2'b10);
    end

    // man_db rise and lock_s fall land on the same edge.
    manual = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("sim_pre_rst", 32'(rst_a), 0);
    end
    pll_lock = 1'b0;
    for (int k = 17; k <= 18; k++) begin
      tick();
      chk("sim_pre_rst", 32'(rst_a), 0);
    end
    tick();
    chk("sim_rst", 32'(rst_a), 32'h7);
    chk("sim_cause", 32'(cause_a), 32'h2);
    chk("sim_state", 32'(u_dut.state_q), 32'(WAIT_LOCK));
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("sim_hold_cause", 32'(cause_a), 32'h2);
      chk("sim_hold_state", 32'(u_dut.state_q), 32'(WAIT_LOCK));
    end
    manual = 1'b0;

    // Late lock: 50 cycles without lock after release.
    do_reset(1'b0);
    for (int k = 0; k < 50; k++) begin
      tick();
      chk("late_rst", 32'(rst_a), 32'h7);
      chk("late_busy", 32'(busy_a), 32'h1);
    end
    pll_lock = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check_dflt(k - 3, 2'b00);
    end

    // Parameter sweep on the N_OUT=1 and N_OUT=8 instances.
    nrst     = 1'b0;
    pll_lock = 1'b1;
    manual   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("sw_rst_n1", 32'(rst_b), 32'h1);
      chk("sw_rst_n8", 32'(rst_c), 32'hff);
    end
    nrst = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      tick();
      check_sweep(k - 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised board-level reset controller that replaces the fixed 3-bit startup counter. It holds every downstream block in reset until the PLL reports lock, then releases `N_OUT` active-high reset outputs in a staggered order. It also handles a debounced manual reset button and lock loss, and records the cause of the last reset. It sits directly under the FPGA top wrapper, between the PLL/buttons and `top`.

## Interface
- `N_OUT`, 3: number of staged reset outputs; must be ≥1.
- `HOLD_CYCLES`, 4: cycles all outputs stay asserted after entering HOLD; must be ≥1.
- `GAP_CYCLES`, 2: cycles between consecutive output releases; must be ≥1.
- `DEBOUNCE_CYCLES`, 16: consecutive stable samples required for the button to change its debounced level; must be ≥2.
- `clk`  in  1  single clock for the whole block.
- `nrst`  in  1  reset, synchronous, active-low; sampled only on `posedge clk`.
- `manual`  in  1  raw push-button reset request, active-high, asynchronous to `clk`.
- `pll_lock`  in  1  PLL lock indicator, asynchronous to `clk`.
- `rst_out`  out  `N_OUT`  active-high resets; bit 0 is released first.
- `busy`  out  1  high whenever state ≠ RUN.
- `rst_done`  out  1  one-cycle pulse on entry to RUN.
- `cause`  out  2  cause of the last reset: 00 = power-on (`nrst`), 01 = manual, 10 = lock loss.

## Operation
- **Input conditioning.**
  - `manual` and `pll_lock` each pass through a 2-flop synchronizer, producing `man_s` and `lock_s`.
  - `man_s` feeds a debouncer whose output is `man_db`. The debounce counter clears whenever `man_s` equals `man_db`. `man_db` toggles after `man_s` has differed from it for `DEBOUNCE_CYCLES` consecutive cycles.
- **States:** WAIT_LOCK, HOLD, RELEASE, RUN.
- **`nrst` low at an edge:**
  - state → WAIT_LOCK; all of `rst_out` = 1; `busy` = 1; `rst_done` = 0; `cause` = 00.
  - All counters, synchronizer flops and `man_db` → 0.
- **WAIT_LOCK:** stay while `lock_s` = 0. When `lock_s` = 1 → HOLD, with hold counter = 0.
- **HOLD:** all of `rst_out` = 1. The counter increments each cycle. When it reaches `HOLD_CYCLES`-1 → RELEASE with idx = 0 and gap counter = 0. While `man_db` = 1 the counter is held at 0, so reset is held for the duration of the button press.
- **RELEASE:**
  - On entry, clear `rst_out[0]`.
  - Each subsequent `GAP_CYCLES` cycles, clear the next bit (idx+1).
  - Once `rst_out[N_OUT-1]` has been cleared → RUN.
  - Released bits stay 0; unreleased bits stay 1.
- **RUN:** `rst_out` = 0 and `busy` = 0.
  - `man_db` 0→1: set `cause` = 01 and go to HOLD. All of `rst_out` = 1 on the next edge.
  - `lock_s` = 0: set `cause` = 10 and go to WAIT_LOCK. All of `rst_out` = 1 on the next edge.
- **Events outside RUN:**
  - `lock_s` = 0 in HOLD or RELEASE: go to WAIT_LOCK, reassert all outputs, `cause` = 10.
  - `man_db` = 1 in RELEASE: go to HOLD, reassert all outputs, `cause` = 01.
  - `man_db` = 1 in WAIT_LOCK: no state change and no effect on `cause`.
- **Simultaneous events:** `nrst` low beats lock loss, which beats manual. When lock loss and manual coincide, `cause` = 10.
- **`N_OUT` = 1:** RELEASE lasts one cycle and goes straight to RUN.

## Timing
- Let edge L be the first edge at which `lock_s` = 1 is sampled in WAIT_LOCK.
- State = HOLD after L.
- `rst_out[i]` goes low after edge L + `HOLD_CYCLES` + i·`GAP_CYCLES`.
- `rst_done` goes high for exactly one cycle after edge L + `HOLD_CYCLES` + (`N_OUT`-1)·`GAP_CYCLES` + 1, and `busy` goes low on the same edge.
- Reassertion of all outputs takes 1 cycle after the event is visible on `lock_s` or `man_db`.
- Latency from input pins:
  - lock loss: 2 cycles of synchronizer plus 1.
  - button: 2 + `DEBOUNCE_CYCLES` + 1.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Counter widths are `$clog2(max(HOLD_CYCLES, GAP_CYCLES, DEBOUNCE_CYCLES, N_OUT)+1)`. No counter ever wraps, because every counter saturates or clears on reaching its terminal value.

## Structure
- Package `reset_seq_pkg` holds:
  - `state_t` enum: WAIT_LOCK, HOLD, RELEASE, RUN.
  - `cause_t` enum: CAUSE_POR = 2'b00, CAUSE_MANUAL = 2'b01, CAUSE_LOCK = 2'b10.
- One sub-module, `sync_debounce` (parameter `DEBOUNCE_CYCLES`), combines the 2-flop synchronizer and the debouncer for `manual`.
- `pll_lock` uses only a bare 2-flop synchronizer inside `reset_sequencer`.

## Test plan
- **Power-on with lock present.**
  - Stimulus: defaults; `pll_lock` = 1 throughout; `nrst` low for 3 cycles, then high.
  - Required: `rst_out` = 111 during `nrst` low. Bits fall at L+4, L+6 and L+8. `rst_done` pulses once. `busy` = 0 afterwards. `cause` = 00.
- **Late lock.**
  - Stimulus: `pll_lock` = 0 for 50 cycles after `nrst` release.
  - Required: `rst_out` = 111 and `busy` = 1 the whole time. Then the same release schedule as the power-on test, measured from the new L.
- **Bouncing button.**
  - Stimulus: in RUN, toggle `manual` every 5 cycles for 60 cycles, then hold it high for 40 cycles.
  - Required: no reset during the toggling. `rst_out` = 111 starting 19 cycles after the stable-high begins. Outputs stay 111 while the button is held. Release resumes after `man_db` falls. `cause` = 01.
- **Lock loss during RELEASE.**
  - Stimulus: drop `pll_lock` right after `rst_out[0]` falls.
  - Required: `rst_out` = 111 within 3 cycles, state WAIT_LOCK, `cause` = 10. After relock, the full sequence repeats.
- **Simultaneous events.**
  - Stimulus: in RUN, `man_db` rises on the same cycle that `lock_s` falls.
  - Required: `cause` = 10 and state WAIT_LOCK.
- **Parameter sweep.**
  - Stimulus: `N_OUT` = 1 with `HOLD_CYCLES` = 1, and `N_OUT` = 8 with `GAP_CYCLES` = 3.
  - Required: release edges exactly as given by the formula in Timing; no X on any output after `nrst`.
